// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential shift-add multiplier.
//   state_e : FSM state encoding (IDLE, CALC, SIGN, DONE)
//   step_w  : width of the per-bit step counter for a given operand width
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int step_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/mult_abs.sv
// mult_abs: combinational two's-complement magnitude.
//   val_i : WIDTH-bit operand
//   en_i  : 1 = treat val_i as signed and return |val_i|; 0 = pass through
//   mag_o : WIDTH-bit unsigned magnitude (most negative value maps to 2^(WIDTH-1))
module mult_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] mag_o
);

   // Negating the most negative value wraps back onto itself, which read as
   // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
   assign mag_o = (en_i && val_i[WIDTH-1]) ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with optional signed mode
// and early termination once the remaining multiplier bits are zero.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : operation request, accepted in IDLE or DONE only
//   signed_i      : operands are two's complement (when SIGNED_EN != 0)
//   a_i, b_i      : multiplier / multiplicand
//   busy_o        : high in CALC and SIGN
//   valid_o       : high in DONE, result_o holds the product
//   result_o      : 2*WIDTH-bit product
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SIGNED_EN = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               valid_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = step_w(WIDTH);

   state_e          state_q, state_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [SW-1:0]    step_q, step_d;
   logic             sign_q, sign_d;
   logic [PW-1:0]    result_q, result_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   // Clear during reset and for the first edge after release, so a start
   // held across reset release is not taken on that edge.
   logic             arm_q;

   logic             sgn_en;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             accept;

   assign sgn_en = (SIGNED_EN != 0) && signed_i;

   mult_abs #(.WIDTH(WIDTH)) u_abs_a (
      .val_i (a_i),
      .en_i  (sgn_en),
      .mag_o (a_mag)
   );

   mult_abs #(.WIDTH(WIDTH)) u_abs_b (
      .val_i (b_i),
      .en_i  (sgn_en),
      .mag_o (b_mag)
   );

   assign accept = arm_q && start_i && (state_q == IDLE || state_q == DONE);

   always_comb begin
      state_d  = state_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      step_d   = step_q;
      sign_d   = sign_q;
      result_d = result_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               mplier_d = a_mag;
               mcand_d  = b_mag;
               sign_d   = sgn_en && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               acc_d    = '0;
               step_d   = '0;
               result_d = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + (PW'(mcand_q) << step_q);
            end
            mplier_d = mplier_q >> 1;
            step_d   = step_q + 1'b1;
            // Stop once no set bits remain above the one just consumed.
            if (mplier_q[WIDTH-1:1] == '0 || step_q == SW'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            result_d = sign_q ? (~acc_q + 1'b1) : acc_q;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d == CALC) || (state_d == SIGN);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         step_q   <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         arm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         step_q   <= step_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         arm_q    <= 1'b1;
      end
   end

   assign busy_o   = busy_q;
   assign valid_o  = valid_q;
   assign result_o = result_q;

endmodule
